// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared FSM state type, reset default, opcode constants and
// instruction field helpers for the instruction fetch unit.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;

  function automatic logic [5:0] opcode_of(input logic [31:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction-memory read port, decoder handshake and branch
// redirect signals of the fetch unit. master = fetch unit, slave = environment.
interface instr_fetch_if #(
  parameter int ADDR_W = 32
);

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;

  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instrucao;
  logic [5:0]        Opcode;
  logic [ADDR_W-1:0] pc_out;

  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instrucao, Opcode, pc_out,
    input  imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instrucao, Opcode, pc_out,
    output imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
  );

endinterface

// File: rtl/instr_fetch_fetch_buffer.sv
// fetch_buffer: 2-entry FIFO of {pc, instruction} sitting between the memory
// and the decoder in the prefetching build. Flush empties both entries.
module fetch_buffer #(
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic [31:0]       push_instr,
  input  logic              pop,
  output logic [ADDR_W-1:0] head_pc,
  output logic [31:0]       head_instr,
  output logic [1:0]        count
);

  logic [ADDR_W-1:0] pc_mem [2];
  logic [31:0]       instr_mem [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign push_ok = push & (count != 2'd2);
  assign pop_ok  = pop & (count != 2'd0);

  // Storage, pointers and occupancy; flush drops everything held.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        pc_mem[wr_ptr]    <= push_pc;
        instr_mem[wr_ptr] <= push_instr;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push_ok) - 2'(pop_ok);
    end
  end

  assign head_pc    = pc_mem[rd_ptr];
  assign head_instr = instr_mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: IDLE/FETCH/HOLD fetch unit feeding the decoder with one held
// instruction at a time. Defining INSTR_FETCH_PREFETCH_EN inserts a 2-entry
// fetch_buffer so fetching overlaps with the decoder holding an instruction.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input logic           clock,
  input logic           reset,
  instr_fetch_if.master bus
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  fetch_state_e      state;
  fetch_state_e      state_next;
  logic [ADDR_W-1:0] pc;
  logic              ack_taken;

  // An ack only means something while a request is actually outstanding.
  assign ack_taken = bus.imem_req & bus.imem_ack;

  // Program counter: redirect wins, otherwise advance on each accepted read.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc <= RESET_PC & ALIGN_MASK;
    end else if (bus.redirect) begin
      pc <= bus.redirect_pc & ALIGN_MASK;
    end else if (ack_taken) begin
      pc <= pc + ADDR_W'(4);
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

`ifdef INSTR_FETCH_PREFETCH_EN
  logic [1:0]        buf_count;
  logic [1:0]        count_next;
  logic              buf_push;
  logic              buf_pop;
  logic [31:0]       head_instr;
  logic [ADDR_W-1:0] head_pc;

  assign buf_push   = ack_taken & ~bus.redirect;
  assign buf_pop    = (buf_count != 2'd0) & bus.instr_ready & ~bus.redirect;
  assign count_next = buf_count + 2'(buf_push) - 2'(buf_pop);

  fetch_buffer #(
    .ADDR_W (ADDR_W)
  ) u_fetch_buffer (
    .clock      (clock),
    .reset      (reset),
    .flush      (bus.redirect),
    .push       (buf_push),
    .push_pc    (pc),
    .push_instr (bus.imem_rdata),
    .pop        (buf_pop),
    .head_pc    (head_pc),
    .head_instr (head_instr),
    .count      (buf_count)
  );

  // Next state: keep fetching until the buffer will be full, then hold.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: state_next = FETCH;
      FETCH, HOLD: begin
        if (bus.redirect) begin
          state_next = FETCH;
        end else if (count_next == 2'd2) begin
          state_next = HOLD;
        end else begin
          state_next = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs: request while fetching, present the buffer head when non-empty.
  always_comb begin
    bus.imem_req    = (state == FETCH);
    bus.imem_addr   = pc;
    bus.instr_valid = (buf_count != 2'd0);
  end

  assign bus.instrucao = head_instr;
  assign bus.pc_out    = head_pc;
`else
  logic [31:0]       instr_q;
  logic [ADDR_W-1:0] pc_q;

  // Capture the returned word and its address unless a redirect discards it.
  always_ff @(posedge clock) begin
    if (reset) begin
      instr_q <= '0;
      pc_q    <= '0;
    end else if (ack_taken && !bus.redirect) begin
      instr_q <= bus.imem_rdata;
      pc_q    <= pc;
    end
  end

  // Next state: fetch until ack, hold until the decoder takes it; redirect restarts.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: state_next = FETCH;
      FETCH: begin
        if (bus.redirect) begin
          state_next = FETCH;
        end else if (ack_taken) begin
          state_next = HOLD;
        end else begin
          state_next = FETCH;
        end
      end
      HOLD: begin
        if (bus.redirect || bus.instr_ready) begin
          state_next = FETCH;
        end else begin
          state_next = HOLD;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs: request only in FETCH, valid only in HOLD.
  always_comb begin
    bus.imem_req    = (state == FETCH);
    bus.imem_addr   = pc;
    bus.instr_valid = (state == HOLD);
  end

  assign bus.instrucao = instr_q;
  assign bus.pc_out    = pc_q;
`endif

  assign bus.Opcode = opcode_of(bus.instrucao);

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized bench for instr_fetch with a transaction-level
// reference model (queue of fetched {pc, word} awaiting the decoder).
// A second instance with RESET_PC = FFFF_FFFC watches the address wrap.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

`ifdef INSTR_FETCH_PREFETCH_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;

  instr_fetch_if #(.ADDR_W(32)) bus ();
  instr_fetch_if #(.ADDR_W(32)) bus2 ();

  instr_fetch #(
    .ADDR_W   (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  instr_fetch #(
    .ADDR_W   (32),
    .RESET_PC (32'hFFFF_FFFC)
  ) dut_wrap (
    .clock (clock),
    .reset (reset),
    .bus   (bus2)
  );

  assign bus2.imem_ack    = 1'b1;
  assign bus2.imem_rdata  = 32'h0000_0000;
  assign bus2.instr_ready = 1'b1;
  assign bus2.redirect    = 1'b0;
  assign bus2.redirect_pc = 32'h0000_0000;

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int transfers = 0;

  // stimulus knobs
  int          readyPct;
  int          redirectPct;
  int          minLat;
  int          maxLat;
  bit          useFixedData;
  logic [31:0] fixedData;
  bit          forceRedirect;
  logic [31:0] forcedPc;

  // reference model state
  logic [31:0] qPc[$];
  logic [31:0] qData[$];
  logic [31:0] mpc;
  bit          idle;
  int          waitCnt;
  int          lat;

  // observation logs
  logic [31:0] xferPc[$];
  logic [5:0]  xferOp[$];
  logic [31:0] addr2[$];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  function automatic int pickLat();
    return int'($urandom_range(maxLat, minLat));
  endfunction

  task automatic resetDut();
    reset            = 1'b1;
    bus.imem_ack     = 1'b1;
    bus.imem_rdata   = $urandom;
    bus.instr_ready  = 1'b1;
    bus.redirect     = 1'b0;
    bus.redirect_pc  = 32'h0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("rst_imem_req", 32'(bus.imem_req), 32'h0);
    checkOutput("rst_instr_valid", 32'(bus.instr_valid), 32'h0);
    checkOutput("rst_instrucao", bus.instrucao, 32'h0);
    checkOutput("rst_pc_out", bus.pc_out, 32'h0);
    reset = 1'b0;
    qPc.delete();
    qData.delete();
    xferPc.delete();
    xferOp.delete();
    addr2.delete();
    mpc     = 32'h0000_0000;
    idle    = 1'b1;
    waitCnt = 0;
    lat     = pickLat();
  endtask

  // One cycle: check outputs against the model, drive inputs, advance the model.
  task automatic applyStimulus();
    bit          expReq;
    bit          expValid;
    bit          doRedirect;
    bit          doReady;
    bit          doAck;
    logic [31:0] rd;
    logic [31:0] rpc;

    expValid = (qPc.size() != 0);
    expReq   = !idle && (qPc.size() < CAP);
    checkOutput("imem_req", 32'(bus.imem_req), 32'(expReq));
    checkOutput("instr_valid", 32'(bus.instr_valid), 32'(expValid));
    if (expReq) begin
      checkOutput("imem_addr", bus.imem_addr, mpc);
    end
    if (bus.imem_req) begin
      checkOutput("addr_align", 32'(bus.imem_addr[1:0]), 32'h0);
    end
    if (expValid) begin
      checkOutput("pc_out", bus.pc_out, qPc[0]);
      checkOutput("instrucao", bus.instrucao, qData[0]);
      checkOutput("Opcode", 32'(bus.Opcode), 32'(qData[0][31:26]));
    end
    if (bus2.imem_req && addr2.size() < 4) begin
      addr2.push_back(bus2.imem_addr);
    end

    doRedirect = forceRedirect || ($urandom_range(0, 99) < readyPct * 0 + redirectPct);
    rpc        = forceRedirect ? forcedPc : $urandom;
    doReady    = ($urandom_range(0, 99) < readyPct);
    if (expReq) begin
      doAck = (waitCnt >= lat);
    end else begin
      doAck = 1'($urandom_range(0, 1));
    end
    rd = useFixedData ? fixedData : $urandom;
    forceRedirect = 1'b0;

    bus.redirect    = doRedirect;
    bus.redirect_pc = rpc;
    bus.instr_ready = doReady;
    bus.imem_ack    = doAck;
    bus.imem_rdata  = rd;

    if (doRedirect) begin
      qPc.delete();
      qData.delete();
      mpc     = rpc & 32'hFFFF_FFFC;
      waitCnt = 0;
      lat     = pickLat();
    end else begin
      if (expValid && doReady) begin
        xferPc.push_back(bus.pc_out);
        xferOp.push_back(bus.Opcode);
        void'(qPc.pop_front());
        void'(qData.pop_front());
        transfers++;
      end
      if (expReq) begin
        if (doAck) begin
          qPc.push_back(mpc);
          qData.push_back(rd);
          mpc     = mpc + 32'd4;
          waitCnt = 0;
          lat     = pickLat();
        end else begin
          waitCnt++;
        end
      end
    end
    idle = 1'b0;

    @(posedge clock);
    #1;
  endtask

  initial begin
    int startXfers;
    readyPct      = 100;
    redirectPct   = 0;
    minLat        = 0;
    maxLat        = 0;
    useFixedData  = 1'b1;
    fixedData     = 32'h8C01_0000;
    forceRedirect = 1'b0;
    forcedPc      = 32'h0;

    // single-cycle memory, decoder always ready; also watch the wrap instance
    resetDut();
    repeat (8) applyStimulus();
    if (xferPc.size() >= 3) begin
      checkOutput("seq_pc0", xferPc[0], 32'h0000_0000);
      checkOutput("seq_pc1", xferPc[1], 32'h0000_0004);
      checkOutput("seq_pc2", xferPc[2], 32'h0000_0008);
      checkOutput("seq_op_lw", 32'(xferOp[0]), 32'(OP_LW));
    end else begin
      checkOutput("seq_len", 32'(xferPc.size()), 32'd3);
    end
    if (addr2.size() >= 2) begin
      checkOutput("wrap_addr0", addr2[0], 32'hFFFF_FFFC);
      checkOutput("wrap_addr1", addr2[1], 32'h0000_0000);
    end else begin
      checkOutput("wrap_len", 32'(addr2.size()), 32'd2);
    end

    // three-cycle memory latency
    useFixedData = 1'b0;
    minLat = 3;
    maxLat = 3;
    resetDut();
    repeat (14) applyStimulus();

    // decoder stalls while an instruction is held
    minLat = 0;
    maxLat = 0;
    readyPct = 0;
    resetDut();
    repeat (7) applyStimulus();
    readyPct = 100;
    repeat (3) applyStimulus();

    // redirect in HOLD together with ready flushes the held word
    readyPct = 0;
    resetDut();
    repeat (3) applyStimulus();
    readyPct = 100;
    forceRedirect = 1'b1;
    forcedPc = 32'h0000_0103;
    startXfers = transfers;
    applyStimulus();
    checkOutput("redir_addr", bus.imem_addr, 32'h0000_0100);
    checkOutput("redir_valid", 32'(bus.instr_valid), 32'h0);
    repeat (4) applyStimulus();
    checkOutput("redir_resume", 32'(transfers > startXfers), 32'h1);

    // randomized traffic with redirects and mid-stream resets
    minLat = 0;
    maxLat = 3;
    readyPct = 70;
    redirectPct = 8;
    startXfers = transfers;
    for (int seg = 0; seg < 3; seg++) begin
      resetDut();
      repeat (400 + int'($urandom_range(0, 100))) applyStimulus();
    end
    checkOutput("progress", 32'(transfers - startXfers > 100), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter ADDR_W, default 32, PC and instruction-memory address width.
REQ-003 Port clock  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port imem_req  output  1  instruction-memory read request.
REQ-006 Port imem_addr  output  ADDR_W  word-aligned read address; low 2 bits always 0.
REQ-007 Port imem_ack  input  1  read complete; imem_rdata valid this cycle.
REQ-008 Port imem_rdata  input  32  instruction word.
REQ-009 Port instr_valid  output  1  instrucao, Opcode and pc_out valid for the decoder.
REQ-010 Port instr_ready  input  1  decoder accepts the presented instruction.
REQ-011 Port instrucao  output  32  held instruction word.
REQ-012 Port Opcode  output  6  equals instrucao[31:26]; feeds the main control decoder.
REQ-013 Port pc_out  output  ADDR_W  address of the presented instruction.
REQ-014 Port redirect  input  1  branch taken; discard fetched work and restart.
REQ-015 Port redirect_pc  input  ADDR_W  restart address; low 2 bits ignored (forced 0).

Function
REQ-016 FSM states IDLE, FETCH, HOLD; IDLE lasts exactly one cycle after reset, then FETCH.
REQ-017 FETCH: imem_req=1, imem_addr=pc; imem_addr stays stable until ack or redirect.
REQ-018 FETCH with imem_ack: capture imem_rdata into instrucao, pc into pc_out, pc<=pc+4, go HOLD.
REQ-019 Ack counts only while imem_req=1; ack in the same cycle as the request is legal (1-cycle fetch).
REQ-020 HOLD: instr_valid=1, outputs stable; instr_ready=1 -> go FETCH next cycle.
REQ-021 Handshake: a transfer occurs on a cycle with instr_valid=1 and instr_ready=1; no transfer is duplicated or dropped.
REQ-022 redirect has priority over ack and ready in every state: pc<=redirect_pc, instr_valid=0 next cycle, go FETCH.
REQ-023 redirect in FETCH with imem_ack same cycle: rdata discarded; next cycle requests redirect_pc.
REQ-024 redirect in HOLD with instr_ready same cycle: the held instruction is flushed, not counted as transferred.
REQ-025 PC arithmetic modulo 2^ADDR_W: pc+4 from 32'hFFFF_FFFC wraps to 0.
REQ-026 Single outstanding memory request at any time; imem_req=0 in IDLE and HOLD.

Reset
REQ-027 On reset: pc=RESET_PC, state=IDLE, imem_req=0, instr_valid=0, instrucao=0, pc_out=0.
REQ-028 Reset mid-fetch abandons the request; a late imem_ack after reset is ignored.

Configuration
REQ-029 Macro INSTR_FETCH_PREFETCH_EN adds a 2-entry instruction buffer between memory and decoder.
REQ-030 With it: fetching continues in HOLD while the buffer is not full; with 1-cycle ack, sustained throughput is 1 instruction per cycle.
REQ-031 With it: redirect empties both entries; full buffer drops imem_req; ordering is strictly FIFO.
REQ-032 Without it: behaviour exactly per REQ-016..026; maximum throughput 1 instruction per 2 cycles.

Structure
REQ-033 Shared package holds: FSM state enum, RESET_PC default, opcode constants OP_RTYPE=0, OP_BEQ=4, OP_LW=35, OP_SW=43, field slices (opcode 31:26).
REQ-034 Sub-module fetch_buffer (2-entry FIFO of {pc, instr}) instantiated only under INSTR_FETCH_PREFETCH_EN.

Verification
REQ-035 Reset, 1-cycle ack, ready=1 always -> pc_out sequence 0,4,8; Opcode matches rdata[31:26] (e.g. 8C01_0000 -> 35).
REQ-036 Ack delayed 3 cycles -> imem_addr stable all 3 cycles; instr_valid rises the cycle after ack.
REQ-037 ready=0 for 4 cycles in HOLD -> instrucao and pc_out unchanged, imem_req=0 (no prefetch build).
REQ-038 redirect=1, redirect_pc=32'h0000_0103 in HOLD with ready=1 -> instruction flushed, next imem_addr=32'h0000_0100.
REQ-039 RESET_PC=32'hFFFF_FFFC -> second fetch address 32'h0000_0000.
REQ-040 Prefetch build, 1-cycle ack, ready=1 -> one transfer per cycle; redirect mid-stream -> no stale pc_out after redirect.
